// File: rtl/key_filter_pkg.sv
// ============================================================================
// Package  : key_filter_pkg
// Purpose  : Shared FSM state encoding and key level constants for key_filter
//            and its downstream consumers (beep driver).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package key_filter_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_FILT = 2'd1,
      DOWN       = 2'd2,
      REL_FILT   = 2'd3
   } key_fsm_e;

   localparam logic KEY_PRESSED  = 1'b0;
   localparam logic KEY_RELEASED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module   : sync_2ff
// Purpose  : 1-bit two-flop synchroniser with configurable reset value.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module sync_2ff #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= d;
         r_sync <= r_meta;
      end
   end

   assign q = r_sync;

endmodule

`default_nettype wire

// File: rtl/key_filter.sv
// ============================================================================
// Module   : key_filter
// Purpose  : Debounces an active-low push button; emits a one-cycle press
//            pulse, a debounced level and (optionally) a release pulse.
// Config   : define KEY_FILTER_RELEASE_EN to enable the key_rel pulse.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module key_filter
   import key_filter_pkg::*;
#(
   parameter int DEB_CNT = 1_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic key_flag,
   output logic key_state,
   output logic key_rel
);

   localparam int               CNT_W      = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
   localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEB_CNT - 1);

   logic             w_sync;
   logic             w_fall;
   logic             w_rise;
   logic             r_hist;
   key_fsm_e         r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_key_flag;
   logic             r_key_state;

   sync_2ff #(
      .RST_VAL (KEY_RELEASED)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_in),
      .q     (w_sync)
   );

   assign w_fall = ~w_sync &  r_hist;
   assign w_rise =  w_sync & ~r_hist;

   // The counter is cleared on every state exit, so it never exceeds c_cnt_last.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hist      <= KEY_RELEASED;
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_key_flag  <= 1'b0;
         r_key_state <= KEY_RELEASED;
      end else begin
         r_hist     <= w_sync;
         r_key_flag <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_fall) begin
                  r_state <= PRESS_FILT;
                  r_cnt   <= '0;
               end
            end
            PRESS_FILT: begin
               if (w_sync != KEY_PRESSED) begin
                  r_state <= IDLE;
                  r_cnt   <= '0;
               end else if (r_cnt == c_cnt_last) begin
                  r_state     <= DOWN;
                  r_cnt       <= '0;
                  r_key_flag  <= 1'b1;
                  r_key_state <= KEY_PRESSED;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            DOWN: begin
               if (w_rise) begin
                  r_state <= REL_FILT;
                  r_cnt   <= '0;
               end
            end
            REL_FILT: begin
               if (w_sync != KEY_RELEASED) begin
                  r_state <= DOWN;
                  r_cnt   <= '0;
               end else if (r_cnt == c_cnt_last) begin
                  r_state     <= IDLE;
                  r_cnt       <= '0;
                  r_key_state <= KEY_RELEASED;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   assign key_flag  = r_key_flag;
   assign key_state = r_key_state;

`ifdef KEY_FILTER_RELEASE_EN
   logic r_key_rel;

   // Fires on the same edge as the REL_FILT -> IDLE transition above.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_key_rel <= 1'b0;
      end else begin
         r_key_rel <= (r_state == REL_FILT) && (w_sync == KEY_RELEASED) &&
                      (r_cnt == c_cnt_last);
      end
   end

   assign key_rel = r_key_rel;
`else
   assign key_rel = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_key_filter.sv
// ============================================================================
// Module   : tb_key_filter
// Purpose  : Self-checking bench for key_filter (DEB_CNT=100, 20 ns clock).
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_key_filter;

   localparam int DEB = 100;
   // Driving at a negedge: first sampling edge is cyc+1, output edge is +DEB+2.
   localparam int LAT = DEB + 3;

   typedef enum int {EV_FLAG, EV_FALL, EV_RISE, EV_REL} ev_kind_e;

   typedef struct {
      ev_kind_e kind;
      int       cyc;
   } ev_t;

   typedef struct {
      int low_len;
      int high_len;
      bit exp_press;
      bit exp_state;
   } vec_t;

   logic clk;
   logic rst_n;
   logic key_in;
   logic key_flag;
   logic key_state;
   logic key_rel;

   int   cyc      = 0;
   int   checks   = 0;
   int   errors   = 0;
   logic mon_prev = 1'b1;
   ev_t  sb[$];
   vec_t vecs[7];

   key_filter #(
      .DEB_CNT (DEB)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_in    (key_in),
      .key_flag  (key_flag),
      .key_state (key_state),
      .key_rel   (key_rel)
   );

   initial begin
      clk = 1'b0;
      forever #10 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b, required %b (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic expect_evt(input ev_kind_e kind);
      ev_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL unexpected_%s: got event at cycle %0d, required none", kind.name(), cyc);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.cyc != cyc) begin
            errors++;
            $display("FAIL event_order: got %s at cycle %0d, required %s at cycle %0d",
                     kind.name(), cyc, e.kind.name(), e.cyc);
         end
      end
   endtask

   task automatic push_edge(input logic lvl, input int t);
      if (lvl == 1'b0) begin
         sb.push_back('{EV_FLAG, t});
         sb.push_back('{EV_FALL, t});
      end else begin
         sb.push_back('{EV_RISE, t});
`ifdef KEY_FILTER_RELEASE_EN
         sb.push_back('{EV_REL, t});
`endif
      end
   endtask

   // Drive one level segment starting at a negedge and hold it n cycles.
   task automatic seg(input logic lvl, input int n, input bit accept);
      key_in = lvl;
      if (accept) push_edge(lvl, cyc + LAT);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every output event must match the head of the scoreboard.
   initial begin
      forever begin
         @(negedge clk);
         if (key_flag === 1'b1) expect_evt(EV_FLAG);
         if (key_state !== mon_prev) expect_evt(key_state ? EV_RISE : EV_FALL);
         if (key_rel === 1'b1) expect_evt(EV_REL);
         if (key_flag || key_rel) check("flag_rel_exclusive", key_flag & key_rel, 1'b0);
         mon_prev = key_state;
      end
   end

   initial begin
      vecs[0] = '{1,   200, 1'b0, 1'b1};
      vecs[1] = '{5,   200, 1'b0, 1'b1};
      vecs[2] = '{50,  200, 1'b0, 1'b1};
      vecs[3] = '{99,  200, 1'b0, 1'b1};
      vecs[4] = '{101, 200, 1'b1, 1'b1};
      vecs[5] = '{150, 200, 1'b1, 1'b1};
      vecs[6] = '{400, 200, 1'b1, 1'b1};

      rst_n  = 1'b0;
      key_in = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("reset_flag",  key_flag,  1'b0);
         check("reset_state", key_state, 1'b1);
         check("reset_rel",   key_rel,   1'b0);
      end
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      // Clean press held 5 us, then clean release
      seg(1'b0, 250, 1'b1);
      check("press_state", key_state, 1'b0);
      seg(1'b1, 250, 1'b1);
      check("release_state", key_state, 1'b1);

      for (int i = 0; i < 7; i++) begin
         seg(1'b0, vecs[i].low_len,  vecs[i].exp_press);
         seg(1'b1, vecs[i].high_len, vecs[i].exp_press);
         check("vec_state", key_state, vecs[i].exp_state);
      end

      // Bounce every 300 ns for 3 us, then settle low
      for (int i = 0; i < 10; i++) begin
         seg(i[0] ? 1'b1 : 1'b0, 15, 1'b0);
      end
      seg(1'b0, 250, 1'b1);
      check("bounce_press_state", key_state, 1'b0);
      seg(1'b1, 250, 1'b1);
      check("bounce_release_state", key_state, 1'b1);

      // Reset in the middle of a press filter
      key_in = 1'b0;
      repeat (50) @(negedge clk);
      rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("midrst_flag",  key_flag,  1'b0);
         check("midrst_state", key_state, 1'b1);
      end
      rst_n = 1'b1;
      push_edge(1'b0, cyc + LAT);
      repeat (250) @(negedge clk);
      check("midrst_press_state", key_state, 1'b0);
      seg(1'b1, 250, 1'b1);

      // Back-to-back press/release cycles
      for (int i = 0; i < 5; i++) begin
         seg(1'b0, 150, 1'b1);
         seg(1'b1, 150, 1'b1);
      end
      repeat (250) @(negedge clk);
      check("final_state", key_state, 1'b1);

      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL pending_events: got %0d outstanding, required 0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
